// File: rtl/result_rd_ctrl.sv
// Result-buffer read controller: streams WORDS_PER_PKT RAM words per packet to a
// valid/ready sink, then releases one upstream buffer slot with a one-cycle pulse.
module result_rd_ctrl #(
  parameter int WORDS_PER_PKT = 5,
  parameter int ADDR_W        = 5,
  parameter int RD_LAT        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              pkt_ready,
  input  logic [511:0]      rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_row_data_done,
  output logic              out_valid,
  output logic [511:0]      out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic [15:0]       pkt_cnt,
  output logic              busy,
  output logic [1:0]        state_dbg
);
  // Handshake: a word transfers on a rising edge where out_valid && out_ready are
  // both high; until then out_valid, out_data and out_last are held unchanged.

  localparam int CNT_W = (WORDS_PER_PKT > 1) ? $clog2(WORDS_PER_PKT) : 1;
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_PKT - 1);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] word_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic             start;
  logic             lat_done;
  logic             hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // pkt_ready is only looked at in IDLE, which always follows DONE by one cycle,
  // so the slot released by the done pulse is already reflected upstream.
  always_comb begin
    state_nxt        = state;
    start            = 1'b0;
    lat_done         = 1'b0;
    hs               = 1'b0;
    rd_row_data_done = 1'b0;
    case (state)
      IDLE: begin
        if (pkt_ready && en) begin
          start     = 1'b1;
          state_nxt = RD;
        end
      end
      RD: begin
        if (lat_cnt == LAT_LAST) begin
          lat_done  = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          hs        = 1'b1;
          state_nxt = out_last ? DONE : RD;
        end
      end
      DONE: begin
        rd_row_data_done = 1'b1;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // rd_addr is never cleared between packets: it tracks the upstream write pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr   <= '0;
      word_cnt  <= '0;
      lat_cnt   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      pkt_cnt   <= '0;
    end else begin
      if (start) begin
        word_cnt <= '0;
        lat_cnt  <= '0;
      end
      if (state == RD) begin
        lat_cnt <= lat_done ? '0 : lat_cnt + 1'b1;
      end
      if (lat_done) begin
        out_data  <= rd_data;
        out_valid <= 1'b1;
        out_last  <= (word_cnt == LAST_WORD);
      end
      if (hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        rd_addr   <= rd_addr + 1'b1;
        word_cnt  <= (word_cnt == LAST_WORD) ? '0 : word_cnt + 1'b1;
      end
      if (rd_row_data_done) begin
        pkt_cnt <= pkt_cnt + 16'd1;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_result_rd_ctrl.sv
// Bench for result_rd_ctrl: upstream packet-buffer model, scoreboard of expected
// words derived from the RAM image, and a decoupled output monitor.
module tb_result_rd_ctrl;
  localparam int WPP = 5;
  localparam int AW  = 5;
  localparam int DEPTH = 32;
  localparam int W   = 513;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic           pkt_ready;
  logic           out_ready = 1'b0;
  logic [511:0]   rd_data;
  logic [511:0]   out_data;
  logic [AW-1:0]  rd_addr;
  logic           rd_row_data_done;
  logic           out_valid;
  logic           out_last;
  logic [15:0]    pkt_cnt;
  logic           busy;
  logic [1:0]     state_dbg;

  logic [511:0]   mem [DEPTH];
  logic [W-1:0]   exp_q[$];

  int  n_total = 0;
  int  n_bad = 0;
  int  avail = 0;
  bit  rel_pend = 0;
  bit  ready_kill = 0;
  int  wptr = 0;
  int  addr_model = 0;
  int  pkt_word = 0;
  int  done_seen = 0;
  int  words_seen = 0;
  int  cyc = 0;
  int  last_done_cyc = -1;
  bit  gap_chk = 0;
  bit  stall_prev = 0;
  logic [511:0] prev_data;
  logic         prev_last;

  result_rd_ctrl #(.WORDS_PER_PKT(WPP), .ADDR_W(AW), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .en(en), .pkt_ready(pkt_ready), .rd_data(rd_data),
    .rd_addr(rd_addr), .rd_row_data_done(rd_row_data_done), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .pkt_cnt(pkt_cnt), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  // RAM: data for the presented address is settled by the next rising edge.
  assign rd_data   = mem[rd_addr];
  assign pkt_ready = (avail > 0) && !ready_kill;

  // Upstream buffer: a done pulse frees one packet slot after the following edge.
  always @(negedge clk) if (!rst && rd_row_data_done) rel_pend = 1;
  always @(posedge clk) begin
    #1;
    if (rel_pend) begin
      avail = avail - 1;
      rel_pend = 0;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_w(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst) begin
      stall_prev = 0;
    end else begin
      cyc++;
      if (stall_prev) begin
        check("hold_valid", int'(out_valid), 1);
        check_w("hold_data", out_data, prev_data);
        check("hold_last", int'(out_last), int'(prev_last));
      end
      if (out_valid) check("rd_addr_of_word", int'(rd_addr), addr_model);
      if (out_valid && out_ready) begin
        check("queue_nonempty", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_w("word_data", out_data, e[511:0]);
          check("word_last", int'(out_last), int'(e[512]));
        end
        addr_model = (addr_model + 1) % DEPTH;
        pkt_word++;
        words_seen++;
      end
      if (rd_row_data_done) begin
        check("done_after_words", pkt_word, WPP);
        check("pkt_cnt_at_done", int'(pkt_cnt), done_seen % 65536);
        if (gap_chk && last_done_cyc >= 0) check("done_gap", cyc - last_done_cyc, WPP * 2 + 2);
        last_done_cyc = cyc;
        done_seen++;
        pkt_word = 0;
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // driver tasks
  task automatic check_reset_vals(input string tag);
    check({tag, "_rd_addr"}, int'(rd_addr), 0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_last"}, int'(out_last), 0);
    check_w({tag, "_out_data"}, out_data, '0);
    check({tag, "_done"}, int'(rd_row_data_done), 0);
    check({tag, "_pkt_cnt"}, int'(pkt_cnt), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic do_reset(input bit chk, input string tag);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;
    exp_q.delete();
    avail = 0; rel_pend = 0; ready_kill = 0; wptr = 0; addr_model = 0;
    pkt_word = 0; done_seen = 0; words_seen = 0; last_done_cyc = -1;
    if (chk) check_reset_vals(tag);
    rst = 0;
  endtask

  task automatic push_pkts(input int n);
    @(posedge clk); #1;
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < WPP; i++) begin
        exp_q.push_back({(i == WPP - 1), mem[wptr]});
        wptr = (wptr + 1) % DEPTH;
      end
    end
    avail = avail + n;
  endtask

  task automatic wait_word(input int k, input string nm);
    bit hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = (pkt_word == k) && !rst;
    end
    check(nm, int'(hit), 1);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      hit = (avail == 0) && !rel_pend && !busy && (exp_q.size() == 0);
    end
    check(nm, int'(hit), 1);
  endtask

  task automatic wait_done_count(input int target, input string nm);
    bit hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = (done_seen >= target);
    end
    check(nm, int'(hit), 1);
  endtask

  initial begin
    logic [511:0] w;
    int n;
    int sum;
    bit hit;
    for (int a = 0; a < DEPTH; a++) begin
      for (int k = 0; k < 16; k++) w[k*32 +: 32] = $urandom;
      mem[a] = w;
    end
    for (int a = 0; a < WPP; a++) mem[a] = 512'(32'hA0 + a);

    do_reset(1, "rst0");

    // single packet A0..A4
    en = 1; out_ready = 1;
    push_pkts(1);
    wait_idle(100, "t1_idle");
    check("t1_pkt_cnt", int'(pkt_cnt), 1);
    check("t1_rd_addr", int'(rd_addr), 5);
    check("t1_done_pulses", done_seen, 1);
    check("t1_words", words_seen, 5);

    // downstream stall of 7 cycles on word 2
    push_pkts(1);
    wait_word(2, "t2_reach_word2");
    @(posedge clk); #1 out_ready = 0;
    repeat (7) @(negedge clk);
    check("t2_stall_valid", int'(out_valid), 1);
    check("t2_stall_rd_addr", int'(rd_addr), 7);
    check("t2_stall_no_done", done_seen, 1);
    check("t2_stall_words", pkt_word, 2);
    @(posedge clk); #1 out_ready = 1;
    wait_idle(100, "t2_idle");
    check("t2_pkt_cnt", int'(pkt_cnt), 2);
    check("t2_rd_addr", int'(rd_addr), 10);

    // seven back-to-back packets from reset, crossing the address wrap
    do_reset(0, "rst1");
    gap_chk = 1;
    push_pkts(7);
    wait_idle(300, "t3_idle");
    gap_chk = 0;
    check("t3_done_pulses", done_seen, 7);
    check("t3_words", words_seen, 35);
    check("t3_rd_addr", int'(rd_addr), 3);
    check("t3_pkt_cnt", int'(pkt_cnt), 7);

    // one buffered packet; pkt_ready also forced low mid-packet
    push_pkts(1);
    wait_word(1, "t4_reach_word1");
    @(posedge clk); #1 ready_kill = 1;
    wait_idle(100, "t4_idle");
    ready_kill = 0;
    repeat (20) @(negedge clk);
    check("t4_busy", int'(busy), 0);
    check("t4_done_pulses", done_seen, 8);
    check("t4_words", words_seen, 40);
    check("t4_pkt_cnt", int'(pkt_cnt), 8);

    // en dropped mid-packet: current packet finishes, next one waits
    push_pkts(2);
    wait_word(1, "t5_reach_word1");
    @(posedge clk); #1 en = 0;
    wait_done_count(9, "t5_first_done");
    repeat (30) @(negedge clk);
    check("t5_held_busy", int'(busy), 0);
    check("t5_held_done", done_seen, 9);
    check("t5_held_queue", exp_q.size(), 5);
    @(posedge clk); #1 en = 1;
    wait_idle(100, "t5_idle");
    check("t5_done_pulses", done_seen, 10);
    check("t5_pkt_cnt", int'(pkt_cnt), 10);
    check("t5_rd_addr", int'(rd_addr), 18);

    // reset during word 3 abandons the packet
    push_pkts(1);
    wait_word(3, "t6_reach_word3");
    do_reset(1, "t6_rst");
    repeat (10) @(negedge clk);
    check("t6_no_done", done_seen, 0);
    check("t6_busy", int'(busy), 0);
    check("t6_rd_addr", int'(rd_addr), 0);

    // randomized backpressure and en
    sum = 0;
    repeat (6) begin
      n = $urandom_range(1, 3);
      sum += n;
      push_pkts(n);
      hit = 0;
      for (int c = 0; c < 800 && !hit; c++) begin
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 3) != 0);
        en = ($urandom_range(0, 7) != 0);
        hit = (avail == 0) && !rel_pend && !busy && (exp_q.size() == 0);
      end
      check("t7_idle", int'(hit), 1);
      out_ready = 1; en = 1;
    end
    repeat (3) @(negedge clk);
    check("t7_done_pulses", done_seen, sum);
    check("t7_pkt_cnt", int'(pkt_cnt), sum);
    check("t7_rd_addr", int'(rd_addr), (sum * WPP) % DEPTH);
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/result_rd_ctrl.md
RESULT_RD_CTRL -- requirements
Module: result_rd_ctrl

Interface
REQ-001 The block SHALL have parameter WORDS_PER_PKT, default 5, meaning number of 512-bit RAM words per packet (two image rows).
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning result-buffer RAM address width (depth 2^ADDR_W = 32).
REQ-003 The block SHALL have parameter RD_LAT, default 1, meaning cycles from rd_addr change to valid rd_data.
REQ-004 clk  input  1  sole clock; all logic rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  start-permission; sampled only in IDLE.
REQ-007 pkt_ready  input  1  high while at least one complete packet is buffered upstream.
REQ-008 rd_data  input  512  RAM read data, valid RD_LAT cycles after rd_addr.
REQ-009 rd_addr  output  ADDR_W  RAM read address, registered.
REQ-010 rd_row_data_done  output  1  one-cycle pulse: packet fully consumed, releases one upstream slot.
REQ-011 out_valid  output  1  out_data valid.
REQ-012 out_data  output  512  packet word, registered.
REQ-013 out_last  output  1  qualifies final word of packet.
REQ-014 out_ready  input  1  downstream accepts word when out_valid&&out_ready.
REQ-015 pkt_cnt  output  16  packets completed since reset, wraps 0xFFFF->0.
REQ-016 busy  output  1  high in any state except IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, RD, SEND, DONE.
REQ-018 IDLE SHALL go to RD when pkt_ready&&en, else remain; word_cnt cleared to 0 on exit.
REQ-019 RD SHALL hold rd_addr stable RD_LAT cycles, then load out_data<=rd_data, set out_valid=1, out_last=(word_cnt==WORDS_PER_PKT-1), go SEND.
REQ-020 SEND SHALL hold out_data, out_valid, out_last stable until out_ready; on handshake: out_valid<=0, rd_addr<=rd_addr+1 (mod 2^ADDR_W), word_cnt<=word_cnt+1.
REQ-021 On SEND handshake with out_last=1 the FSM SHALL go DONE; otherwise RD.
REQ-022 DONE SHALL last exactly one cycle with rd_row_data_done=1 and pkt_cnt incremented once, then go IDLE.
REQ-023 rd_row_data_done SHALL be 0 in all other states; exactly one pulse per packet.
REQ-024 IDLE SHALL sample pkt_ready no earlier than the cycle after DONE, so a buffer holding one packet is not re-read.
REQ-025 rd_addr SHALL never be reset between packets; it wraps 31->0 continuously, matching the upstream write pointer, including packets straddling the wrap.
REQ-026 en deasserted mid-packet SHALL NOT abort the packet; it only blocks the next IDLE->RD.
REQ-027 pkt_ready falling mid-packet SHALL be ignored until IDLE.
REQ-028 Minimum per-word cost SHALL be RD_LAT+1 cycles with out_ready held high; packet cost WORDS_PER_PKT*(RD_LAT+1)+1 cycles plus one IDLE cycle.
REQ-029 word_cnt SHALL be wide enough for WORDS_PER_PKT-1 and never exceed it.

Reset
REQ-030 On rst: state=IDLE, rd_addr=0, word_cnt=0, out_valid=0, out_last=0, out_data=0, rd_row_data_done=0, pkt_cnt=0, busy=0.
REQ-031 rst asserted mid-packet SHALL abandon the packet with no rd_row_data_done pulse; upstream reset together with this block is required.

Verification
REQ-032 Reset, pkt_ready=1, en=1, out_ready=1, RAM words 0..4 hold 0xA0..0xA4 -> five words A0..A4 out, out_last only on A4, one done pulse, pkt_cnt=1, rd_addr=5.
REQ-033 out_ready=0 for 7 cycles on word 2 -> out_data/out_last held stable, rd_addr unchanged, no done pulse until word 4 accepted.
REQ-034 Seven back-to-back packets (pkt_ready held) -> 7 done pulses, 35 words, rd_addr reads 30,31,0,1,2 in packet 7, ends at 3, pkt_cnt=7.
REQ-035 pkt_ready=1 for one packet only (drops cycle after done) -> exactly one packet sent, FSM returns to IDLE, busy=0.
REQ-036 en dropped during word 1 -> packet completes; next packet not started until en=1 again.
REQ-037 rst pulsed during word 3 -> all outputs at reset values next cycle, no done pulse, rd_addr=0.
